parallel_shift_register: RTL and testbench

- Parameterised parallel-load / serial-in shift register; default width 4 bits.
- Each clock edge it either loads a parallel word, shifts right by one with a serial input bit entering at the MSB, or holds.
- Used as a generic datapath storage/serialiser element; the LSB is exposed as a serial output for chaining stages.

---
 rtl/parallel_shift_register_pkg.sv | 27 ++
 rtl/parallel_shift_register.sv | 50 +++++
 tb/tb_parallel_shift_register.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/parallel_shift_register_pkg.sv
// Shared definitions for the parallel_shift_register block.
//
// Contents:
//   op_t       - the single operation the register performs on a clock edge
//   decode_op  - resolves the control inputs into one op_t using the fixed
//                priority reset > load > shift > hold
package parallel_shift_register_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_SHIFT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_RESET = 2'd3
  } op_t;

  // Priority is encoded here once so the register body is a flat case.
  function automatic op_t decode_op(input logic rst, input logic load,
                                    input logic shift);
    op_t op;
    if (rst)        op = OP_RESET;
    else if (load)  op = OP_LOAD;
    else if (shift) op = OP_SHIFT;
    else            op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/parallel_shift_register.sv
// Parallel-load / serial-in shift-right register.
//
// Each rising edge of clk the register either resets to zero, loads D,
// shifts right by one with SerI entering at the MSB, or holds.
//
// Ports:
//   clk    in   system clock, rising-edge
//   rst    in   synchronous active-high reset (beats everything)
//   L      in   parallel load enable (beats Shift)
//   Shift  in   shift-right enable
//   SerI   in   serial input, enters at Q[WIDTH-1] on a shift
//   D      in   [WIDTH-1:0] parallel load data
//   Q      out  [WIDTH-1:0] register contents, straight from the flops
//   SerO   out  serial output, always equal to Q[0]
//
// There is no handshake: every edge applies exactly one operation.
module parallel_shift_register
  import parallel_shift_register_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             L,
  input  logic             Shift,
  input  logic             SerI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SerO
);

  op_t op;

  assign op = decode_op(rst, L, Shift);

  // D is only sampled on a load, so an undefined D never leaks into Q
  // while L is low.
  always_ff @(posedge clk) begin
    case (op)
      OP_RESET: Q <= '0;
      OP_LOAD:  Q <= D;
      OP_SHIFT: Q <= {SerI, Q[WIDTH-1:1]};
      default:  Q <= Q;
    endcase
  end

  // The bit leaving on the next shift is visible now, for chaining stages.
  assign SerO = Q[0];

endmodule

// File: tb/tb_parallel_shift_register.sv
// Self-checking bench for parallel_shift_register (WIDTH = 4).
//
// The driver applies one directed vector per clock and pushes the
// hand-computed {Q, SerO} expected after that edge into exp_q. An
// independent monitor pops one entry after every rising edge and compares.
module tb_parallel_shift_register;

  localparam int WIDTH = 4;
  localparam int EW    = WIDTH + 1;

  logic             clk;
  logic             rst;
  logic             L;
  logic             Shift;
  logic             SerI;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             SerO;

  logic [EW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;
  bit            drive_done = 0;

  parallel_shift_register #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .L     (L),
    .Shift (Shift),
    .SerI  (SerI),
    .D     (D),
    .Q     (Q),
    .SerO  (SerO)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- driver ----------------
  // Apply inputs on the falling edge; exp_val is the Q expected after the
  // following rising edge, exp_ser the expected SerO at that time.
  task automatic step(input logic r, input logic l, input logic s,
                      input logic si, input logic [WIDTH-1:0] d,
                      input logic [WIDTH-1:0] exp_val, input logic exp_ser);
    @(negedge clk);
    rst   = r;
    L     = l;
    Shift = s;
    SerI  = si;
    D     = d;
    exp_q.push_back({exp_val, exp_ser});
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [EW-1:0] exp;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if ({Q, SerO} !== exp) begin
          errors++;
          $display("FAIL check%0d: Q=%b SerO=%b expected Q=%b SerO=%b",
                   checks, Q, SerO, exp[EW-1:1], exp[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; L = 1'b0; Shift = 1'b0; SerI = 1'b0; D = '0;

    //     rst   L     Shift SerI  D        Q after   SerO
    // reset beats load
    step(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 4'b0000, 1'b0);
    // load, then hold three edges
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 4'b1011, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1011, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1011, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1011, 1'b1);
    // shift with zero fill; SerO walks out 1,1,0,1
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0101, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0010, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
    // reload, shift ones in until full, then zeros
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0011, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1001, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1100, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1110, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1111, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0111, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0011, 1'b1);
    // clear, then load and shift together: load wins
    step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 4'b1010, 1'b0);
    // build 1100, reset mid-shift, resume shifting
    step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 4'b0011, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1001, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1100, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b1000, 1'b0);
    // D changes while L is low: no effect
    step(1'b0, 1'b0, 1'b0, 1'b1, 4'b1111, 4'b1000, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 4'b1000, 1'b0);
    // reset beats shift and load together
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0);
    drive_done = 1'b1;
  end

  // ---------------- final report ----------------
  initial begin
    int budget;
    wait (drive_done);
    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
